// File: rtl/vga_pwm_pkg.sv
// vga_pwm_pkg
//   Shared widths, constants and pixel structs for the VGA PWM dither decoder.
//   - PHASE_W / CH_W / OUT_W : phase tag, dithered channel and recovered channel widths
//   - PHASE_SYNC             : phase value held while sync is asserted (first tag of a line)
//   - CH_MAX                 : full-scale dithered sample
//   - rgb18_t / rgb24_t      : {R,G,B} views of the 18-bit input and 24-bit output
//   - dither_level()         : sample value the encoder emits for a given base/frac/tag
package vga_pwm_pkg;

    localparam int PHASE_W = 2;
    localparam int CH_W    = 6;
    localparam int OUT_W   = 8;

    localparam logic [PHASE_W-1:0] PHASE_SYNC = 2'd3;
    localparam logic [CH_W-1:0]    CH_MAX     = 6'd63;

    // Result for an all-full-scale window: filled to white or left at the raw sum.
    localparam logic [OUT_W-1:0] SAT_FULL  = 8'hFF;
    localparam logic [OUT_W-1:0] SAT_TRUNC = 8'hFC;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb18_t;

    typedef struct packed {
        logic [OUT_W-1:0] r;
        logic [OUT_W-1:0] g;
        logic [OUT_W-1:0] b;
    } rgb24_t;

    // The encoder adds one LSB on the first 'frac' phases of each window.
    // base+1 cannot overflow here: base is 63 only when the sum is 252,
    // which forces frac=0.
    function automatic logic [CH_W-1:0] dither_level(
        input logic [CH_W-1:0]    base,
        input logic [1:0]         frac,
        input logic [PHASE_W-1:0] tag
    );
        return base + CH_W'(tag < frac);
    endfunction

endpackage

// File: rtl/vga_pwm_chan_dec.sv
// vga_pwm_chan_dec
//   One colour channel of the dither decoder. Keeps the last four active samples with
//   their phase tags, sums them into the 8-bit recovered value, applies the
//   saturation rule and checks every sample against the dither pattern implied by
//   the sum. Outputs are combinational from the stored window; the top level decides
//   when a window is complete and registers the result.
//   Ports:
//     clk, reset_n  clock / async active-low reset
//     sample_en     shift sample+tag into the window (active sample this cycle)
//     sample        6-bit dithered sample
//     tag           phase tag of this sample
//     value         recovered 8-bit channel value of the stored window
//     pat_bad       stored window does not match the dither pattern
module vga_pwm_chan_dec
    import vga_pwm_pkg::*;
#(
    parameter bit SAT_FILL = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sample_en,
    input  logic [CH_W-1:0]    sample,
    input  logic [PHASE_W-1:0] tag,
    output logic [OUT_W-1:0]   value,
    output logic               pat_bad
);

    logic [3:0][CH_W-1:0]    smp_q;
    logic [3:0][PHASE_W-1:0] tag_q;

    logic [OUT_W-1:0] sum;
    logic [CH_W-1:0]  base;
    logic [1:0]       frac;
    logic             all_max;
    logic             mismatch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            smp_q <= '0;
            tag_q <= '0;
        end else if (sample_en) begin
            smp_q <= {smp_q[2:0], sample};
            tag_q <= {tag_q[2:0], tag};
        end
    end

    always_comb begin
        sum     = '0;
        all_max = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sum = sum + OUT_W'(smp_q[i]);
            if (smp_q[i] != CH_MAX) begin
                all_max = 1'b0;
            end
        end

        base = sum[OUT_W-1:2];
        frac = sum[1:0];

        mismatch = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (smp_q[i] != dither_level(base, frac, tag_q[i])) begin
                mismatch = 1'b1;
            end
        end

        // A clipped window cannot reproduce the pattern, so it is never flagged.
        if (all_max) begin
            value = SAT_FILL ? SAT_FULL : SAT_TRUNC;
        end else begin
            value = sum;
        end
        pat_bad = mismatch && !all_max;
    end

endmodule

// File: rtl/vga_pwm_decode.sv
// vga_pwm_decode
//   Receive side of the VGA PWM dither link. Rebuilds 24-bit RGB from the 18-bit
//   dithered stream by summing runs of four active samples per channel, and flags
//   windows whose samples do not follow the encoder's per-phase dither pattern.
//   Ports:
//     clk         pixel clock, one sample per cycle
//     reset_n     asynchronous active-low reset
//     csync_en    1: phase follows csync, 0: phase follows hsync
//     hsync       horizontal sync, active high
//     csync       composite sync, active high
//     din         {R[5:0],G[5:0],B[5:0]} dithered samples
//     err_clr     clears err_sticky
//     dout        {R[7:0],G[7:0],B[7:0]} recovered pixel, held between windows
//     dout_valid  one-cycle pulse when dout carries a new window result
//     pat_err     one-cycle pulse with dout_valid when the window failed the pattern check
//     err_sticky  set by any pattern error, held until err_clr
module vga_pwm_decode
    import vga_pwm_pkg::*;
#(
    parameter int SYNC_DLY = 1,
    parameter bit SAT_FILL = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        csync_en,
    input  logic        hsync,
    input  logic        csync,
    input  logic [17:0] din,
    input  logic        err_clr,
    output logic [23:0] dout,
    output logic        dout_valid,
    output logic        pat_err,
    output logic        err_sticky
);

    logic               sync_sel;
    logic               sd;
    logic [PHASE_W-1:0] phase;
    logic [1:0]         win_cnt;
    logic               win_full;
    logic               sample_en;
    rgb18_t             din_s;
    rgb24_t             win_value;
    logic               bad_r;
    logic               bad_g;
    logic               bad_b;
    logic               win_err;

    // The selector is not registered on its own: a csync_en change rides the same
    // delay line as the sync it selects.
    assign sync_sel = csync_en ? csync : hsync;

    // Delay line resets to "in sync" so nothing is sampled until a real line starts.
    if (SYNC_DLY == 0) begin : g_sync_nodly
        assign sd = sync_sel;
    end else if (SYNC_DLY == 1) begin : g_sync_dly1
        logic sync_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_q <= 1'b1;
            end else begin
                sync_q <= sync_sel;
            end
        end
        assign sd = sync_q;
    end else begin : g_sync_dlyn
        logic [SYNC_DLY-1:0] sync_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_q <= '1;
            end else begin
                sync_q <= {sync_q[SYNC_DLY-2:0], sync_sel};
            end
        end
        assign sd = sync_q[SYNC_DLY-1];
    end

    assign sample_en = !sd;
    assign din_s     = rgb18_t'(din);

    // Phase tags each active sample; sync parks it at 3 so every line starts
    // with the tag sequence 3,0,1,2. win_full marks that the channel windows
    // hold four samples of one window and are decoded in the next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase    <= PHASE_SYNC;
            win_cnt  <= '0;
            win_full <= 1'b0;
        end else if (sd) begin
            phase    <= PHASE_SYNC;
            win_cnt  <= '0;
            win_full <= 1'b0;
        end else begin
            phase    <= phase + 2'd1;
            win_cnt  <= win_cnt + 2'd1;
            win_full <= (win_cnt == 2'd3);
        end
    end

    vga_pwm_chan_dec #(.SAT_FILL(SAT_FILL)) u_dec_r (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample_en (sample_en),
        .sample    (din_s.r),
        .tag       (phase),
        .value     (win_value.r),
        .pat_bad   (bad_r)
    );

    vga_pwm_chan_dec #(.SAT_FILL(SAT_FILL)) u_dec_g (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample_en (sample_en),
        .sample    (din_s.g),
        .tag       (phase),
        .value     (win_value.g),
        .pat_bad   (bad_g)
    );

    vga_pwm_chan_dec #(.SAT_FILL(SAT_FILL)) u_dec_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample_en (sample_en),
        .sample    (din_s.b),
        .tag       (phase),
        .value     (win_value.b),
        .pat_bad   (bad_b)
    );

    assign win_err = bad_r || bad_g || bad_b;

    // err_sticky is set both while the error is being registered and during the
    // pat_err pulse, so a clear that overlaps either cycle still loses to the set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            pat_err    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            dout_valid <= win_full;
            pat_err    <= win_full && win_err;
            if (win_full) begin
                dout <= win_value;
            end
            err_sticky <= (win_full && win_err) || pat_err || (err_sticky && !err_clr);
        end
    end

endmodule

// File: tb/tb_vga_pwm_decode.sv
module tb_vga_pwm_decode;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        csync_en;
    logic        hsync;
    logic        csync;
    logic [17:0] din;
    logic        err_clr;
    logic [23:0] dout0, dout1;
    logic        v0, v1, pe0, pe1, st0, st1;

    always #5 clk = ~clk;

    vga_pwm_decode #(.SYNC_DLY(1), .SAT_FILL(1'b1)) dut0 (
        .clk(clk), .reset_n(reset_n), .csync_en(csync_en), .hsync(hsync), .csync(csync),
        .din(din), .err_clr(err_clr), .dout(dout0), .dout_valid(v0), .pat_err(pe0),
        .err_sticky(st0)
    );

    vga_pwm_decode #(.SYNC_DLY(1), .SAT_FILL(1'b0)) dut1 (
        .clk(clk), .reset_n(reset_n), .csync_en(csync_en), .hsync(hsync), .csync(csync),
        .din(din), .err_clr(err_clr), .dout(dout1), .dout_valid(v1), .pat_err(pe1),
        .err_sticky(st1)
    );

    typedef struct packed {
        logic [23:0] e0;
        logic [23:0] e1;
        logic        perr;
    } exp_t;

    typedef struct packed {
        logic [3:0][5:0] r;
        logic [3:0][5:0] g;
        logic [3:0][5:0] b;
        logic [23:0]     e0;
        logic [23:0]     e1;
        logic            perr;
    } vec_t;

    exp_t        sbq[$];
    exp_t        cur_exp;
    exp_t        popped;
    vec_t        vt[7];
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_valid = 0;
    int          act_cnt = 0;
    bit          use_cs = 1'b0;
    logic [17:0] din_pend = '0;
    logic [23:0] last_exp0 = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Encoder model: one extra LSB on the first 'frac' phases, clipped at full scale.
    function automatic logic [5:0] enc_ch(input logic [7:0] v, input logic [1:0] tag);
        logic [6:0] lvl;
        lvl = {1'b0, v[7:2]} + 7'(tag < v[1:0]);
        if (lvl > 7'd63) lvl = 7'd63;
        return lvl[5:0];
    endfunction

    function automatic logic [17:0] enc(input logic [23:0] px, input logic [1:0] tag);
        return {enc_ch(px[23:16], tag), enc_ch(px[15:8], tag), enc_ch(px[7:0], tag)};
    endfunction

    function automatic vec_t mkv(
        input logic [5:0] r0, r1, r2, r3, g0, g1, g2, g3, b0, b1, b2, b3,
        input logic [23:0] e0, e1, input logic pe);
        vec_t v;
        v.r[0] = r0; v.r[1] = r1; v.r[2] = r2; v.r[3] = r3;
        v.g[0] = g0; v.g[1] = g1; v.g[2] = g2; v.g[3] = g3;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
        v.e0 = e0; v.e1 = e1; v.perr = pe;
        return v;
    endfunction

    // One pixel cycle: sync for this cycle, din lags sync by one cycle like the
    // registered encoder output. Every 4th consecutive active sample queues a result.
    task automatic step(input logic act, input logic [17:0] d);
        if (use_cs) begin
            csync = ~act; hsync = 1'b0;
        end else begin
            hsync = ~act; csync = 1'b0;
        end
        din = din_pend;
        din_pend = d;
        if (act) begin
            act_cnt++;
            if (act_cnt == 4) begin
                sbq.push_back(cur_exp);
                last_exp0 = cur_exp.e0;
                act_cnt = 0;
            end
        end else begin
            act_cnt = 0;
        end
        @(negedge clk);
    endtask

    task automatic blank(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 18'h0);
    endtask

    task automatic apply_vec(input vec_t v);
        cur_exp = '{e0: v.e0, e1: v.e1, perr: v.perr};
        blank(3);
        for (int j = 0; j < 4; j++) step(1'b1, {v.r[j], v.g[j], v.b[j]});
        blank(4);
    endtask

    task automatic run_line(input logic [23:0] px, input int n_act, input logic [23:0] e0,
                            input logic [23:0] e1);
        cur_exp = '{e0: e0, e1: e1, perr: 1'b0};
        blank(3);
        for (int i = 0; i < n_act; i++) step(1'b1, enc(px, 2'(i + 3)));
        blank(4);
    endtask

    // Output side of the scoreboard.
    always @(posedge clk) begin
        #1;
        if (v0 || v1) begin
            n_valid++;
            if (sbq.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid: got dout %h with no window pending (t=%0t)",
                         dout0, $time);
            end else begin
                popped = sbq.pop_front();
                chk("valid_sf1", 32'(v0), 32'd1);
                chk("valid_sf0", 32'(v1), 32'd1);
                chk("dout_sf1", 32'(dout0), 32'(popped.e0));
                chk("dout_sf0", 32'(dout1), 32'(popped.e1));
                chk("pat_err_sf1", 32'(pe0), 32'(popped.perr));
                chk("pat_err_sf0", 32'(pe1), 32'(popped.perr));
            end
        end else if (pe0 || pe1) begin
            n_checks++;
            $display("FAIL pat_err_no_valid: got %b/%b expected 0 (t=%0t)", pe0, pe1, $time);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int vbefore;
        logic [23:0] held;

        vt[0] = mkv(10,11,10,10, 0,0,0,0, 32,32,32,32, 24'h290080, 24'h290080, 1'b0);
        vt[1] = mkv(10,10,11,10, 0,0,0,0, 32,32,32,32, 24'h290080, 24'h290080, 1'b1);
        vt[2] = mkv(20,21,21,21, 1,1,1,1, 62,63,63,63, 24'h5304FB, 24'h5304FB, 1'b0);
        vt[3] = mkv(63,63,63,63, 63,63,63,63, 63,63,63,63, 24'hFFFFFF, 24'hFCFCFC, 1'b0);
        vt[4] = mkv(0,1,0,0, 5,5,5,6, 0,0,0,0, 24'h011500, 24'h011500, 1'b1);
        vt[5] = mkv(63,63,63,63, 63,63,63,62, 7,8,8,7, 24'hFFFB1E, 24'hFCFB1E, 1'b1);
        vt[6] = mkv(0,0,0,0, 0,1,1,1, 40,41,40,40, 24'h0003A1, 24'h0003A1, 1'b0);

        reset_n = 1'b0; csync_en = 1'b0; hsync = 1'b1; csync = 1'b0;
        din = '0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_dout", 32'(dout0), 32'h0);
        chk("reset_valid", 32'(v0), 32'h0);
        chk("reset_pat_err", 32'(pe0), 32'h0);
        chk("reset_sticky", 32'(st0), 32'h0);
        chk("reset_phase", 32'(dut0.phase), 32'd3);
        reset_n = 1'b1;
        blank(2);

        // Loopback with the encoder over a full line, plus a clipped colour.
        vbefore = n_valid;
        run_line(24'h8D417B, 640, 24'h8D417B, 24'h8D417B);
        chk("loop_valid_count", 32'(n_valid - vbefore), 32'd160);
        chk("loop_sticky", 32'(st0), 32'h0);
        run_line(24'hFEFDFC, 16, 24'hFFFFFF, 24'hFCFCFC);

        // Direct-drive windows.
        for (int i = 0; i < 7; i++) apply_vec(vt[i]);
        chk("table_sticky_set", 32'(st0), 32'h1);

        // err_clr alone clears.
        err_clr = 1'b1; step(1'b0, 18'h0); err_clr = 1'b0;
        chk("clr_alone", 32'(st0), 32'h0);

        // err_clr overlapping a new error: set wins.
        cur_exp = '{e0: vt[1].e0, e1: vt[1].e1, perr: 1'b1};
        blank(3);
        for (int j = 0; j < 4; j++) step(1'b1, {vt[1].r[j], vt[1].g[j], vt[1].b[j]});
        step(1'b0, 18'h0);
        err_clr = 1'b1;
        step(1'b0, 18'h0);
        step(1'b0, 18'h0);
        err_clr = 1'b0;
        step(1'b0, 18'h0);
        chk("clr_vs_set", 32'(st0), 32'h1);
        err_clr = 1'b1; step(1'b0, 18'h0); err_clr = 1'b0;
        chk("clr_after", 32'(st0), 32'h0);
        blank(2);

        // Partial window cut off by sync: no output, dout held.
        vbefore = n_valid;
        held = last_exp0;
        blank(3);
        step(1'b1, {6'd9, 6'd9, 6'd9});
        step(1'b1, {6'd9, 6'd9, 6'd9});
        blank(6);
        chk("partial_no_valid", 32'(n_valid - vbefore), 32'd0);
        chk("partial_dout_held", 32'(dout0), 32'(held));
        chk("partial_no_err", 32'(st0), 32'h0);
        apply_vec(vt[2]);

        // Reset in the middle of a window.
        cur_exp = '{e0: vt[1].e0, e1: vt[1].e1, perr: 1'b1};
        blank(3);
        for (int j = 0; j < 4; j++) step(1'b1, {vt[1].r[j], vt[1].g[j], vt[1].b[j]});
        step(1'b1, {6'd5, 6'd5, 6'd5});
        step(1'b1, {6'd5, 6'd5, 6'd5});
        step(1'b1, {6'd5, 6'd5, 6'd5});
        chk("pre_reset_sticky", 32'(st0), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_dout", 32'(dout0), 32'h0);
        chk("async_rst_valid", 32'(v0), 32'h0);
        chk("async_rst_sticky", 32'(st0), 32'h0);
        chk("async_rst_phase", 32'(dut0.phase), 32'd3);
        act_cnt = 0;
        din_pend = '0;
        sbq.delete();
        step(1'b0, 18'h0);
        reset_n = 1'b1;
        apply_vec(vt[6]);

        // Sync source selection; 6 actives per line leave a partial window that only
        // the selected sync can discard.
        csync_en = 1'b1; use_cs = 1'b1;
        blank(2);
        run_line(24'h5A3C96, 6, 24'h5A3C96, 24'h5A3C96);
        run_line(24'h07F881, 6, 24'h07F881, 24'h07F881);
        csync_en = 1'b0; use_cs = 1'b0;
        blank(2);
        run_line(24'h07F881, 6, 24'h07F881, 24'h07F881);
        run_line(24'h5A3C96, 6, 24'h5A3C96, 24'h5A3C96);

        blank(8);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
